// File: rtl/key_cmd_parser.sv
// key_cmd_parser
//
// Turns a stream of ASCII key characters into single-byte commands and
// BCD-entry commands (set time / set alarm), presented on a valid/ready
// command port with a one-deep pending slot.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   charData       ASCII character
//   charDataValid  charData is valid this cycle (one character per cycle)
//   cmd_ready      consumer accepts the pending command
//   cmd_valid      a command is pending, held until accepted
//   cmd_code       1 START, 2 STOP, 3 LOAD, 4 SELECT, 5 SET_TIME,
//                  6 SET_ALARM, 7 CLEAR
//   cmd_value      packed BCD, first-entered digit in the MS nibble
//   busy           numeric entry in progress
//   err_pulse      one-cycle pulse: character rejected during an entry
//   overrun        one-cycle pulse: character dropped, command pending
//
// State table
//   IDLE    | waiting for a command key; single-key commands issue here
//   DIGITS  | collecting NDIG BCD digits for SET_TIME / SET_ALARM
//   CONFIRM | all digits in, waiting for CR (commit) or ESC (abort)

module key_cmd_parser #(
    parameter int                NDIG      = 4,
    parameter logic [NDIG-1:0]   LIM5_MASK = NDIG'(4'b1010),
    parameter int                FOLD_CASE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          charData,
    input  logic                charDataValid,
    input  logic                cmd_ready,
    output logic                cmd_valid,
    output logic [2:0]          cmd_code,
    output logic [4*NDIG-1:0]   cmd_value,
    output logic                busy,
    output logic                err_pulse,
    output logic                overrun
);

    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

    localparam logic [2:0] C_START     = 3'd1;
    localparam logic [2:0] C_STOP      = 3'd2;
    localparam logic [2:0] C_LOAD      = 3'd3;
    localparam logic [2:0] C_SELECT    = 3'd4;
    localparam logic [2:0] C_SET_TIME  = 3'd5;
    localparam logic [2:0] C_SET_ALARM = 3'd6;
    localparam logic [2:0] C_CLEAR     = 3'd7;

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_ESC = 8'h1B;
    localparam logic [7:0] CH_AT  = 8'h40;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIGITS  = 2'd1,
        CONFIRM = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*NDIG-1:0]   shift_q, shift_d;
    logic [2:0]          pend_q, pend_d;
    logic                valid_q, valid_d;
    logic [2:0]          code_q, code_d;
    logic [4*NDIG-1:0]   value_q, value_d;
    logic                err_q, err_d;
    logic                ovr_q, ovr_d;

    logic                is_digit;
    logic                digit_ok;
    logic [NDIG-1:0]     mask_sh;
    logic [CW-1:0]       cnt_inc;
    logic                slot_blocked;

    // Upper-case letter key match; the lower-case form only matches when
    // folding is enabled. Any character with bit 7 set can never equal k.
    function automatic logic key_is(input logic [7:0] c, input logic [7:0] k);
        logic hit;
        hit = (c == k);
        if (FOLD_CASE != 0 && c == (k | 8'h20)) begin
            hit = 1'b1;
        end
        return hit;
    endfunction

    assign is_digit = (charData >= 8'h30) && (charData <= 8'h39);

    // Shifting the mask left by the count puts the limit bit of the digit
    // currently being entered into the MSB, avoiding a computed index.
    assign mask_sh  = LIM5_MASK << cnt_q;
    assign digit_ok = is_digit && (!mask_sh[NDIG-1] || charData <= 8'h35);
    assign cnt_inc  = cnt_q + 1'b1;

    // The slot is blocked only when the pending command is not being taken
    // this cycle; a simultaneous accept frees it for a back-to-back issue.
    assign slot_blocked = valid_q && !cmd_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pend_d  = pend_q;
        valid_d = valid_q && !cmd_ready;
        code_d  = code_q;
        value_d = value_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;

        if (charDataValid) begin
            if (slot_blocked) begin
                ovr_d = 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (key_is(charData, "S")) begin
                            valid_d = 1'b1;
                            code_d  = C_START;
                            value_d = '0;
                        end else if (charData == CH_CR) begin
                            valid_d = 1'b1;
                            code_d  = C_STOP;
                            value_d = '0;
                        end else if (key_is(charData, "L")) begin
                            valid_d = 1'b1;
                            code_d  = C_LOAD;
                            value_d = '0;
                        end else if (key_is(charData, "N")) begin
                            valid_d = 1'b1;
                            code_d  = C_SELECT;
                            value_d = '0;
                        end else if (charData == CH_ESC) begin
                            valid_d = 1'b1;
                            code_d  = C_CLEAR;
                            value_d = '0;
                        end else if (charData == CH_AT) begin
                            state_d = DIGITS;
                            pend_d  = C_SET_TIME;
                            cnt_d   = '0;
                            shift_d = '0;
                        end else if (key_is(charData, "A")) begin
                            state_d = DIGITS;
                            pend_d  = C_SET_ALARM;
                            cnt_d   = '0;
                            shift_d = '0;
                        end
                    end

                    DIGITS: begin
                        if (charData == CH_ESC) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            shift_d = '0;
                            valid_d = 1'b1;
                            code_d  = C_CLEAR;
                            value_d = '0;
                        end else if (digit_ok) begin
                            shift_d      = shift_q << 4;
                            shift_d[3:0] = charData[3:0];
                            cnt_d        = cnt_inc;
                            if (cnt_inc == NDIG_C) begin
                                state_d = CONFIRM;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end

                    CONFIRM: begin
                        if (charData == CH_CR) begin
                            state_d = IDLE;
                            valid_d = 1'b1;
                            code_d  = pend_q;
                            value_d = shift_q;
                            cnt_d   = '0;
                            shift_d = '0;
                        end else if (charData == CH_ESC) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            shift_d = '0;
                            valid_d = 1'b1;
                            code_d  = C_CLEAR;
                            value_d = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end

                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            value_q <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            value_q <= value_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_code  = code_q;
    assign cmd_value = value_q;
    assign busy      = (state_q != IDLE);
    assign err_pulse = err_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_key_cmd_parser.sv
// Testbench for key_cmd_parser: one instance with default parameters (A)
// and one with NDIG=2, LIM5_MASK=2'b10, FOLD_CASE=0 (B). Each vector holds
// the inputs for one clock and the outputs expected after that edge.

module tb_key_cmd_parser;

    typedef struct {
        logic        sel;
        logic        rst;
        logic        v;
        logic [7:0]  ch;
        logic        rdy;
        logic        ev;
        logic [2:0]  ec;
        logic [15:0] eval;
        logic        eb;
        logic        ee;
        logic        eo;
    } vec_t;

    logic        clk;
    logic        rst_n;

    logic [7:0]  a_ch;
    logic        a_v;
    logic        a_rdy;
    logic        a_valid;
    logic [2:0]  a_code;
    logic [15:0] a_value;
    logic        a_busy;
    logic        a_err;
    logic        a_ovr;

    logic [7:0]  b_ch;
    logic        b_v;
    logic        b_rdy;
    logic        b_valid;
    logic [2:0]  b_code;
    logic [7:0]  b_value;
    logic        b_busy;
    logic        b_err;
    logic        b_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    key_cmd_parser u_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .charData      (a_ch),
        .charDataValid (a_v),
        .cmd_ready     (a_rdy),
        .cmd_valid     (a_valid),
        .cmd_code      (a_code),
        .cmd_value     (a_value),
        .busy          (a_busy),
        .err_pulse     (a_err),
        .overrun       (a_ovr)
    );

    key_cmd_parser #(
        .NDIG      (2),
        .LIM5_MASK (2'b10),
        .FOLD_CASE (0)
    ) u_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .charData      (b_ch),
        .charDataValid (b_v),
        .cmd_ready     (b_rdy),
        .cmd_valid     (b_valid),
        .cmd_code      (b_code),
        .cmd_value     (b_value),
        .busy          (b_busy),
        .err_pulse     (b_err),
        .overrun       (b_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic sel, input logic rst, input logic v,
                                input logic [7:0] ch, input logic rdy,
                                input logic ev, input logic [2:0] ec,
                                input logic [15:0] eval, input logic eb,
                                input logic ee, input logic eo);
        vec_t t;
        t.sel = sel; t.rst = rst; t.v = v; t.ch = ch; t.rdy = rdy;
        t.ev = ev; t.ec = ec; t.eval = eval; t.eb = eb; t.ee = ee; t.eo = eo;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, expv);
        end
    endtask

    // Drive one vector (called just after a falling edge), queue its
    // expectation, then compare at the next falling edge.
    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        logic        av;
        logic [2:0]  ac;
        logic [15:0] aval;
        logic        ab, ae, ao;
        rst_n = t.rst;
        if (t.sel == 1'b0) begin
            a_v = t.v; a_ch = t.ch; a_rdy = t.rdy; b_v = 1'b0;
        end else begin
            b_v = t.v; b_ch = t.ch; b_rdy = t.rdy; a_v = 1'b0;
        end
        exp_q.push_back(t);
        @(negedge clk);
        e = exp_q.pop_front();
        if (e.sel == 1'b0) begin
            av = a_valid; ac = a_code; aval = a_value;
            ab = a_busy; ae = a_err; ao = a_ovr;
        end else begin
            av = b_valid; ac = b_code; aval = {8'h00, b_value};
            ab = b_busy; ae = b_err; ao = b_ovr;
        end
        chk("cmd_valid", idx, {15'd0, av}, {15'd0, e.ev});
        chk("busy",      idx, {15'd0, ab}, {15'd0, e.eb});
        chk("err_pulse", idx, {15'd0, ae}, {15'd0, e.ee});
        chk("overrun",   idx, {15'd0, ao}, {15'd0, e.eo});
        if (e.ev) begin
            chk("cmd_code",  idx, {13'd0, ac}, {13'd0, e.ec});
            chk("cmd_value", idx, aval, e.eval);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_ch = 8'h00; a_v = 1'b0; a_rdy = 1'b1;
        b_ch = 8'h00; b_v = 1'b0; b_rdy = 1'b1;

        // reset: inputs ignored, everything zero
        vecs.push_back(mk(0,0,1,"S",1,    0,0,0,       0,0,0));
        vecs.push_back(mk(0,0,0,8'h00,1,  0,0,0,       0,0,0));
        // SET_TIME 1234
        vecs.push_back(mk(0,1,1,"@",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"1",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"2",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"3",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"4",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,8'h0D,1,  1,5,16'h1234,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00,1,  0,0,0,       0,0,0));
        // SET_ALARM with range error and confirm-stage error
        vecs.push_back(mk(0,1,1,"a",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"6",1,    0,0,0,       1,1,0));
        vecs.push_back(mk(0,1,1,"5",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"9",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"5",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"9",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"X",1,    0,0,0,       1,1,0));
        vecs.push_back(mk(0,1,1,8'h0D,1,  1,6,16'h5959,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00,1,  0,0,0,       0,0,0));
        // abort with ESC, then STOP back-to-back
        vecs.push_back(mk(0,1,1,"@",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"1",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"2",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,8'h1B,1,  1,7,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,1,8'h0D,1,  1,2,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00,1,  0,0,0,       0,0,0));
        // case folding, ignored keys, bit 7 never matches
        vecs.push_back(mk(0,1,1,"n",1,    1,4,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,1,"x",1,    0,0,0,       0,0,0));
        vecs.push_back(mk(0,1,1,8'hD3,1,  0,0,0,       0,0,0));
        // handshake: hold, overrun, simultaneous accept + new command
        vecs.push_back(mk(0,1,1,"s",0,    1,1,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,1,"L",0,    1,1,16'h0000,0,0,1));
        vecs.push_back(mk(0,1,0,8'h00,0,  1,1,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,1,"N",1,    1,4,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00,1,  0,0,0,       0,0,0));
        // reset mid-entry
        vecs.push_back(mk(0,1,1,"@",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,1,1,"1",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,1,  0,0,0,       0,0,0));
        vecs.push_back(mk(0,1,1,"2",1,    0,0,0,       0,0,0));
        vecs.push_back(mk(0,1,1,8'h0D,1,  1,2,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00,1,  0,0,0,       0,0,0));
        // reset with a pending command
        vecs.push_back(mk(0,1,1,"S",0,    1,1,16'h0000,0,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,  0,0,0,       0,0,0));
        vecs.push_back(mk(0,1,0,8'h00,0,  0,0,0,       0,0,0));
        vecs.push_back(mk(0,1,0,8'h00,1,  0,0,0,       0,0,0));
        // instance B: NDIG=2, upper case only
        vecs.push_back(mk(1,1,1,"s",1,    0,0,0,       0,0,0));
        vecs.push_back(mk(1,1,1,"S",1,    1,1,16'h0000,0,0,0));
        vecs.push_back(mk(1,1,1,"@",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(1,1,1,"5",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(1,1,1,"9",1,    0,0,0,       1,0,0));
        vecs.push_back(mk(1,1,1,"7",1,    0,0,0,       1,1,0));
        vecs.push_back(mk(1,1,1,8'h0D,1,  1,5,16'h0059,0,0,0));
        vecs.push_back(mk(1,1,0,8'h00,1,  0,0,0,       0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // long stall: command held stable while every character overruns,
        // and an entry attempted during the stall must not start
        apply(mk(0,1,1,"L",0, 1,3,16'h0000,0,0,0), 100);
        for (int k = 0; k < 4; k++) begin
            apply(mk(0,1,1,"@",0, 1,3,16'h0000,0,0,1), 101 + k);
        end
        apply(mk(0,1,0,8'h00,1, 0,0,0,0,0,0), 105);
        apply(mk(0,1,1,"1",1,   0,0,0,0,0,0), 106);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_cmd_parser.md
KEY_CMD_PARSER -- requirements
Module: key_cmd_parser

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits in a numeric entry; legal range 1-8.
REQ-002 Parameter LIM5_MASK, default 4'b1010 (width NDIG): bit i=1 limits digit i to '0'-'5', bit i=0 allows '0'-'9'; digit NDIG-1 is entered first.
REQ-003 Parameter FOLD_CASE, default 1: 1 means letters match upper or lower case; 0 means upper case only.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 charData  input  8  ASCII character.
REQ-007 charDataValid  input  1  charData is valid this cycle; one character per asserted cycle.
REQ-008 cmd_ready  input  1  consumer accepts the pending command.
REQ-009 cmd_valid  output  1  a command is pending; held until accepted.
REQ-010 cmd_code  output  3  command: 1 START, 2 STOP, 3 LOAD, 4 SELECT, 5 SET_TIME, 6 SET_ALARM, 7 CLEAR.
REQ-011 cmd_value  output  4*NDIG  packed BCD; first-entered digit in the MS nibble; zero for non-numeric commands.
REQ-012 busy  output  1  a numeric entry is in progress (state DIGITS or CONFIRM).
REQ-013 err_pulse  output  1  one-cycle pulse: a character was rejected during an entry.
REQ-014 overrun  output  1  one-cycle pulse: a character was dropped because a command was pending.

Function
REQ-015 Decode SHALL be registered. A character sampled in cycle N affects outputs in cycle N+1.
REQ-016 FSM states SHALL be IDLE, DIGITS, CONFIRM.
REQ-017 Commands from IDLE:
- 'S' -> START; CR (0x0D) -> STOP; 'L' -> LOAD; 'N' -> SELECT; ESC (0x1B) -> CLEAR.
- Each issues cmd_valid with cmd_value=0, and the FSM stays in IDLE.
REQ-018 IDLE: '@' enters DIGITS with pending code SET_TIME; 'A' enters DIGITS with pending code SET_ALARM. In both cases the digit count and shift register are cleared.
REQ-019 IDLE: any other character is ignored silently; no err_pulse.
REQ-020 DIGITS: an in-range digit is shifted into the LS nibble and the count increments; when the count reaches NDIG, go to CONFIRM.
REQ-021 DIGITS: the range check uses LIM5_MASK bit (NDIG-1-count). An out-of-range digit or a non-digit character (other than ESC) pulses err_pulse and leaves state and count unchanged.
REQ-022 CONFIRM: CR issues the pending code with cmd_value equal to the shift register, then returns to IDLE.
REQ-023 CONFIRM: any character other than CR or ESC pulses err_pulse and stays in CONFIRM.
REQ-024 ESC in DIGITS or CONFIRM aborts the entry to IDLE, issues CLEAR, and discards the digits.
REQ-025 Handshake:
- cmd_valid, cmd_code and cmd_value are stable while cmd_valid=1 and cmd_ready=0.
- A transfer occurs in a cycle with cmd_valid=1 and cmd_ready=1.
- cmd_valid drops the next cycle unless a new command is issued in that cycle.
REQ-026 Pending slot: if charDataValid=1 and cmd_valid=1 and cmd_ready=0, the character is dropped, overrun pulses, and FSM state is unchanged.
REQ-027 Simultaneous: if cmd_ready=1 and charDataValid=1 while cmd_valid=1, the character is processed normally and may issue the next command back-to-back.
REQ-028 cmd_ready while cmd_valid=0 SHALL have no effect.
REQ-029 Letters SHALL be matched under FOLD_CASE (bit 5 ignored only when FOLD_CASE=1); charData[7]=1 never matches any key.
REQ-030 charDataValid=0 SHALL leave all state unchanged; err_pulse and overrun are 0 in the following cycle.

Reset
REQ-031 When rst_n=0 at a rising clk edge, the following SHALL clear to 0: FSM=IDLE, count, shift register, pending code, cmd_valid, cmd_code, cmd_value, busy, err_pulse, overrun.
REQ-032 Reset during an entry or with a pending command SHALL discard both; no command is issued after reset.
REQ-033 Inputs SHALL be ignored in any cycle with rst_n=0.

Verification
REQ-034 Defaults, cmd_ready=1: "@","1","2","3","4",CR -> single cmd_valid pulse with code 5 and value 16'h1234; busy is 1 from after '@' until the CR is processed.
REQ-035 Defaults: "a","6" -> err_pulse, count unchanged; then "5","9","5","9",CR -> code 6, value 16'h5959.
REQ-036 cmd_ready=0: 's' -> code 1 held; 'L' -> overrun pulse, output still code 1; raise cmd_ready with 'N' in the same cycle -> code 4 valid next cycle.
REQ-037 "@","1","2",ESC -> code 7, value 0, busy=0; a following CR -> code 2 (STOP).
REQ-038 NDIG=2, LIM5_MASK=2'b10, FOLD_CASE=0: 's' ignored, no command; "@","5","9","7" -> err_pulse on '7'; CR -> code 5, value 8'h59.
REQ-039 Pulse rst_n=0 for 1 cycle after "@","1": all outputs 0, FSM=IDLE; a following "2",CR -> code 2 only, with value 0.
